// File: rtl/fd_pipe_reg_if.sv
// F/D pipeline register bus: fetch-side inputs and decode-side outputs.
//   master : fetch/hazard side (drives stall, exc_flush, instr_f, pc_f)
//   slave  : fd_pipe_reg (drives instr_d, pc_d, pc8_d, exccode_d, bd_d, valid_d)
interface fd_pipe_reg_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned EXCW = 5;

  logic            stall;
  logic            exc_flush;
  logic [XLEN-1:0] instr_f;
  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] instr_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc8_d;
  logic [EXCW-1:0] exccode_d;
  logic            bd_d;
  logic            valid_d;

  modport master (
    output stall, exc_flush, instr_f, pc_f,
    input  instr_d, pc_d, pc8_d, exccode_d, bd_d, valid_d
  );

  modport slave (
    input  stall, exc_flush, instr_f, pc_f,
    output instr_d, pc_d, pc8_d, exccode_d, bd_d, valid_d
  );
endinterface

// File: rtl/fd_pipe_reg.sv
// F/D pipeline register of the five-stage MIPS CPU.
// Latches the fetched instruction and PC, tags fetch address errors (AdEL)
// and flags whether the held instruction sits in a branch delay slot.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - fd_pipe_reg_if.slave: stall, exc_flush, instr_f, pc_f in;
//           instr_d, pc_d, pc8_d (combinational pc_d+8), exccode_d, bd_d,
//           valid_d out
// Optional build macro: FD_PC_RANGE_CHECK_EN adds a PC_LO..PC_HI fetch
// range check on top of the word-alignment check.
module fd_pipe_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_LO    = 32'h0000_3000,
  parameter logic [31:0] PC_HI    = 32'h0000_6ffc,
  parameter logic [4:0]  EXC_ADEL = 5'd4
) (
  input  logic         clk,
  input  logic         reset,
  fd_pipe_reg_if.slave bus
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned EXCW = 5;

`ifdef FD_PC_RANGE_CHECK_EN
  localparam logic RANGE_EN = 1'b1;
`else
  localparam logic RANGE_EN = 1'b0;
`endif

  logic [XLEN-1:0] ir_q,  ir_d;
  logic [XLEN-1:0] pcr_q, pcr_d;
  logic [EXCW-1:0] exc_q, exc_d;
  logic            bd_q,  bd_d;
  logic            vld_q, vld_d;

  logic misalign;
  logic out_of_range;
  logic fetch_err;

  // True for any branch or jump, i.e. the next fetched word is a delay slot.
  function automatic logic is_bj(input logic [XLEN-1:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    logic       hit;
    op  = ins[31:26];
    fn  = ins[5:0];
    hit = 1'b0;
    case (op)
      6'b000001, 6'b000010, 6'b000011,
      6'b000100, 6'b000101, 6'b000110, 6'b000111: hit = 1'b1;
      6'b000000: hit = (fn == 6'b001000) || (fn == 6'b001001);
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Fetch address error detection.
  always_comb begin
    misalign     = (bus.pc_f[1:0] != 2'b00);
    out_of_range = (bus.pc_f < PC_LO) || (bus.pc_f > PC_HI);
    fetch_err    = misalign || (RANGE_EN && out_of_range);
  end

  // Next-state: flush beats stall beats normal load.
  always_comb begin
    ir_d  = ir_q;
    pcr_d = pcr_q;
    exc_d = exc_q;
    bd_d  = bd_q;
    vld_d = vld_q;
    if (bus.exc_flush) begin
      ir_d  = '0;
      pcr_d = bus.pc_f;
      exc_d = '0;
      bd_d  = 1'b0;
      vld_d = 1'b0;
    end else if (!bus.stall) begin
      pcr_d = bus.pc_f;
      vld_d = 1'b1;
      // bd comes from the predecessor, so a squashed AdEL word still gets it.
      bd_d  = is_bj(ir_q);
      if (fetch_err) begin
        ir_d  = '0;
        exc_d = EXC_ADEL;
      end else begin
        ir_d  = bus.instr_f;
        exc_d = '0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q  <= '0;
      pcr_q <= RESET_PC;
      exc_q <= '0;
      bd_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      ir_q  <= ir_d;
      pcr_q <= pcr_d;
      exc_q <= exc_d;
      bd_q  <= bd_d;
      vld_q <= vld_d;
    end
  end

  assign bus.instr_d   = ir_q;
  assign bus.pc_d      = pcr_q;
  assign bus.pc8_d     = pcr_q + XLEN'(8);
  assign bus.exccode_d = exc_q;
  assign bus.bd_d      = bd_q;
  assign bus.valid_d   = vld_q;

endmodule

// File: tb/tb_fd_pipe_reg.sv
// Directed scoreboard bench for fd_pipe_reg: stimulus pushes the expected
// D-stage view per edge; a monitor pops and compares after each edge or on
// an explicit asynchronous-check event.
module tb_fd_pipe_reg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic [4:0]  exc;
    logic        bd;
    logic        valid;
  } exp_t;

  logic clk;
  logic reset;
  fd_pipe_reg_if bus ();

  fd_pipe_reg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb_q[$];
  event chk_ev;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_field(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc,
                              input logic [4:0] exc, input logic bd,
                              input logic valid);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    e.pc8   = pc + 32'd8;
    e.exc   = exc;
    e.bd    = bd;
    e.valid = valid;
    return e;
  endfunction

  // Monitor: compare the oldest expectation after each edge or async check.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_field("instr_d",   bus.instr_d,           e.instr);
        check_field("pc_d",      bus.pc_d,              e.pc);
        check_field("pc8_d",     bus.pc8_d,             e.pc8);
        check_field("exccode_d", 32'(bus.exccode_d),    32'(e.exc));
        check_field("bd_d",      32'(bus.bd_d),         32'(e.bd));
        check_field("valid_d",   32'(bus.valid_d),      32'(e.valid));
      end
    end
  end

  // Drive one cycle of F inputs at negedge and queue the post-edge result.
  task automatic step(input logic st, input logic fl, input logic [31:0] ins,
                      input logic [31:0] pc, input exp_t e);
    bus.stall     = st;
    bus.exc_flush = fl;
    bus.instr_f   = ins;
    bus.pc_f      = pc;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  localparam logic [4:0] ADEL = 5'd4;

  initial begin
    exp_t e_reset;
    exp_t e_adel_held;
    exp_t e_range;
    exp_t e_wrap;
    int   waited;

    e_reset = mk(32'h0, 32'h3000, 5'd0, 1'b0, 1'b0);

    reset         = 1'b0;
    bus.stall     = 1'b0;
    bus.exc_flush = 1'b0;
    bus.instr_f   = 32'h3421_0001;
    bus.pc_f      = 32'h0000_3000;

    // Reset state, checked between edges.
    @(negedge clk);
    #2;
    sb_q.push_back(e_reset);
    -> chk_ev;
    @(negedge clk);
    reset = 1'b1;

    // First load, then beq / delay slot / past the slot.
    step(0, 0, 32'h3421_0001, 32'h3000, mk(32'h3421_0001, 32'h3000, 5'd0, 1'b0, 1'b1));
    step(0, 0, 32'h1000_0003, 32'h3004, mk(32'h1000_0003, 32'h3004, 5'd0, 1'b0, 1'b1));
    step(0, 0, 32'hac22_0000, 32'h3008, mk(32'hac22_0000, 32'h3008, 5'd0, 1'b1, 1'b1));
    step(0, 0, 32'h0022_1821, 32'h300c, mk(32'h0022_1821, 32'h300c, 5'd0, 1'b0, 1'b1));
    // Misaligned fetch: squashed, AdEL tagged.
    step(0, 0, 32'h8c01_0000, 32'h3002, mk(32'h0,         32'h3002, ADEL, 1'b0, 1'b1));
    // jr, then an out-of-range aligned PC in its delay slot.
    step(0, 0, 32'h03e0_0008, 32'h3010, mk(32'h03e0_0008, 32'h3010, 5'd0, 1'b0, 1'b1));
`ifdef FD_PC_RANGE_CHECK_EN
    e_range = mk(32'h0,         32'h7000, ADEL, 1'b1, 1'b1);
`else
    e_range = mk(32'h3442_0005, 32'h7000, 5'd0, 1'b1, 1'b1);
`endif
    step(0, 0, 32'h3442_0005, 32'h7000, e_range);
    // jal followed by a squashed misaligned word: bd still set.
    step(0, 0, 32'h0c00_0c00, 32'h3014, mk(32'h0c00_0c00, 32'h3014, 5'd0, 1'b0, 1'b1));
    e_adel_held = mk(32'h0, 32'h3019, ADEL, 1'b1, 1'b1);
    step(0, 0, 32'h2401_0001, 32'h3019, e_adel_held);
    // Stall for three cycles while fetch inputs change.
    step(1, 0, 32'h1111_1111, 32'h301c, e_adel_held);
    step(1, 0, 32'h0800_0000, 32'h3020, e_adel_held);
    step(1, 0, 32'h03e0_0008, 32'h3021, e_adel_held);
    // Flush wins over stall.
    step(1, 1, 32'h1234_5678, 32'h4180, mk(32'h0, 32'h4180, 5'd0, 1'b0, 1'b0));
    // Load jal, then assert reset between edges.
    step(0, 0, 32'h0c00_0d00, 32'h3020, mk(32'h0c00_0d00, 32'h3020, 5'd0, 1'b0, 1'b1));
    #2;
    reset = 1'b0;
    sb_q.push_back(e_reset);
    -> chk_ev;
    @(negedge clk);
    reset = 1'b1;
    // First post-reset load must not inherit the jal's delay slot.
    step(0, 0, 32'h3421_0001, 32'h3000, mk(32'h3421_0001, 32'h3000, 5'd0, 1'b0, 1'b1));
    // regimm, then jalr, each flagging the following word.
    step(0, 0, 32'h0411_0001, 32'h3004, mk(32'h0411_0001, 32'h3004, 5'd0, 1'b0, 1'b1));
    step(0, 0, 32'h0040_f809, 32'h3008, mk(32'h0040_f809, 32'h3008, 5'd0, 1'b1, 1'b1));
    step(0, 0, 32'h0000_0000, 32'h300c, mk(32'h0,         32'h300c, 5'd0, 1'b1, 1'b1));
    // pc8 wraps at the top of the address space.
`ifdef FD_PC_RANGE_CHECK_EN
    e_wrap = mk(32'h0,         32'hffff_fffc, ADEL, 1'b0, 1'b1);
`else
    e_wrap = mk(32'h2401_0001, 32'hffff_fffc, 5'd0, 1'b0, 1'b1);
`endif
    step(0, 0, 32'h2401_0001, 32'hffff_fffc, e_wrap);

    // Drain the scoreboard with a bounded wait.
    waited = 0;
    while (sb_q.size() > 0 && waited < 5) begin
      @(posedge clk);
      #2;
      waited++;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
